// File: rtl/operand_sequencer.sv
// Multi-cycle operand sequencer: fetches two operands from register file, data memory
// or immediate, presents them to the ALU, then writes the result back to the destination.
module operand_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int VALUE_WIDTH  = 8,
  parameter int MEM_WIDTH    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [OPCODE_WIDTH-1:0] op_code,
  input  logic [MEM_WIDTH-1:0]    source1_addr,
  input  logic [MEM_WIDTH-1:0]    source2_addr,
  input  logic [MEM_WIDTH-1:0]    dest_addr,
  input  logic [1:0]              source1_choice,
  input  logic [1:0]              source2_choice,
  input  logic [1:0]              dest_choice,
  output logic [MEM_WIDTH-1:0]    rf_raddr1,
  output logic [MEM_WIDTH-1:0]    rf_raddr2,
  input  logic [VALUE_WIDTH-1:0]  rf_rdata1,
  input  logic [VALUE_WIDTH-1:0]  rf_rdata2,
  output logic                    rf_we,
  output logic [MEM_WIDTH-1:0]    rf_waddr,
  output logic [VALUE_WIDTH-1:0]  rf_wdata,
  output logic [MEM_WIDTH-1:0]    mem_addr,
  output logic                    mem_re,
  input  logic [VALUE_WIDTH-1:0]  mem_rdata,
  output logic                    mem_we,
  output logic [VALUE_WIDTH-1:0]  mem_wdata,
  output logic [OPCODE_WIDTH-1:0] alu_op,
  output logic [VALUE_WIDTH-1:0]  alu_a,
  output logic [VALUE_WIDTH-1:0]  alu_b,
  input  logic [VALUE_WIDTH-1:0]  alu_out,
  output logic                    done,
  output logic                    err
);

  localparam logic [1:0] LOC_REG  = 2'b00;
  localparam logic [1:0] LOC_MEM  = 2'b01;
  localparam logic [1:0] LOC_IMM  = 2'b10;

  typedef enum logic [2:0] {IDLE, S1_RD, S1_WT, S2_RD, S2_WT, EXEC, WB} state_t;

  state_t                 state;
  logic [MEM_WIDTH-1:0]   src1_addr;
  logic [MEM_WIDTH-1:0]   src2_addr;
  logic [MEM_WIDTH-1:0]   dst_addr;
  logic [1:0]             src1_sel;
  logic [1:0]             src2_sel;
  logic [1:0]             dst_sel;
  logic [VALUE_WIDTH-1:0] result;

  // Non-memory operand value: register data, zero-extended immediate, or zero for "none".
  function automatic logic [VALUE_WIDTH-1:0] direct_operand(
    input logic [1:0]             sel,
    input logic [VALUE_WIDTH-1:0] rdata,
    input logic [MEM_WIDTH-1:0]   addr
  );
    logic [VALUE_WIDTH-1:0] val;
    case (sel)
      LOC_REG: val = rdata;
      LOC_IMM: val = VALUE_WIDTH'(addr);
      default: val = '0;
    endcase
    return val;
  endfunction

  assign rf_raddr1 = src1_addr;
  assign rf_raddr2 = src2_addr;
  assign rf_waddr  = dst_addr;
  assign rf_wdata  = result;
  assign mem_wdata = result;

  // Strobes are registered on the transition into the cycle in which they must be high,
  // so the single memory port serves reads (S1_RD/S2_RD) and the write (WB) in turn.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      src1_addr   <= '0;
      src2_addr   <= '0;
      dst_addr    <= '0;
      src1_sel    <= '0;
      src2_sel    <= '0;
      dst_sel     <= '0;
      result      <= '0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      mem_addr    <= '0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      rf_we       <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      rf_we  <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            alu_op      <= op_code;
            src1_addr   <= source1_addr;
            src2_addr   <= source2_addr;
            dst_addr    <= dest_addr;
            src1_sel    <= source1_choice;
            src2_sel    <= source2_choice;
            dst_sel     <= dest_choice;
            instr_ready <= 1'b0;
            mem_re      <= (source1_choice == LOC_MEM);
            mem_addr    <= source1_addr;
            state       <= S1_RD;
          end
        end
        S1_RD: begin
          if (src1_sel == LOC_MEM) begin
            state <= S1_WT;
          end else begin
            alu_a    <= direct_operand(src1_sel, rf_rdata1, src1_addr);
            mem_re   <= (src2_sel == LOC_MEM);
            mem_addr <= src2_addr;
            state    <= S2_RD;
          end
        end
        S1_WT: begin
          alu_a    <= mem_rdata;
          mem_re   <= (src2_sel == LOC_MEM);
          mem_addr <= src2_addr;
          state    <= S2_RD;
        end
        S2_RD: begin
          if (src2_sel == LOC_MEM) begin
            state <= S2_WT;
          end else begin
            alu_b <= direct_operand(src2_sel, rf_rdata2, src2_addr);
            state <= EXEC;
          end
        end
        S2_WT: begin
          alu_b <= mem_rdata;
          state <= EXEC;
        end
        EXEC: begin
          result <= alu_out;
          rf_we  <= (dst_sel == LOC_REG);
          mem_we <= (dst_sel == LOC_MEM);
          err    <= (dst_sel == LOC_IMM);
          done   <= 1'b1;
          if (dst_sel == LOC_MEM) begin
            mem_addr <= dst_addr;
          end
          state  <= WB;
        end
        WB: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench for operand_sequencer: a tracker pushes expected retirements at each
// accept, a monitor pops and compares them whenever the DUT signals done.
module tb_operand_sequencer;

  localparam int OW = 4;
  localparam int VW = 8;
  localparam int MW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [OW-1:0] op_code = '0;
  logic [MW-1:0] source1_addr = '0, source2_addr = '0, dest_addr = '0;
  logic [1:0]    source1_choice = '0, source2_choice = '0, dest_choice = '0;
  logic [MW-1:0] rf_raddr1, rf_raddr2, rf_waddr, mem_addr;
  logic [VW-1:0] rf_rdata1, rf_rdata2, rf_wdata, mem_rdata, mem_wdata;
  logic          rf_we, mem_re, mem_we, done, err;
  logic [OW-1:0] alu_op;
  logic [VW-1:0] alu_a, alu_b, alu_out;

  logic [VW-1:0] env_rf [32];
  logic [VW-1:0] env_mem[32];
  logic [VW-1:0] model_rf [32];
  logic [VW-1:0] model_mem[32];

  logic          pre_we = 1'b0;
  logic          pre_sel = 1'b0;
  logic [MW-1:0] pre_addr = '0;
  logic [VW-1:0] pre_data = '0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_accepts = 0;
  int acc_cur = 0;
  int acc_prev = 0;
  int obs_n = 0;
  logic [MW-1:0] obs_addr[2];

  typedef struct {
    logic [OW-1:0] op;
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic [VW-1:0] res;
    logic [1:0]    dch;
    logic [MW-1:0] daddr;
    int            lat;
    int            acc;
    int            nrd;
    logic [MW-1:0] rd[2];
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  operand_sequencer #(.OPCODE_WIDTH(OW), .VALUE_WIDTH(VW), .MEM_WIDTH(MW)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .op_code(op_code),
    .source1_addr(source1_addr), .source2_addr(source2_addr), .dest_addr(dest_addr),
    .source1_choice(source1_choice), .source2_choice(source2_choice), .dest_choice(dest_choice),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .done(done), .err(err)
  );

  // Reference ALU used both as the DUT's combinational ALU and by the model.
  function automatic logic [VW-1:0] alu_fn(input logic [OW-1:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return b;
      default: return a;
    endcase
  endfunction

  function automatic logic [VW-1:0] fetch(input logic [1:0] ch, input logic [MW-1:0] addr);
    case (ch)
      2'b00:   return model_rf[addr];
      2'b01:   return model_mem[addr];
      2'b10:   return VW'(addr);
      default: return '0;
    endcase
  endfunction

  assign alu_out   = alu_fn(alu_op, alu_a, alu_b);
  assign rf_rdata1 = env_rf[rf_raddr1];
  assign rf_rdata2 = env_rf[rf_raddr2];

  // Register file and data memory environment; mem_rdata arrives one cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) env_mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= env_mem[mem_addr];
    if (rf_we) env_rf[rf_waddr] <= rf_wdata;
    if (pre_we && pre_sel) env_mem[pre_addr] <= pre_data;
    if (pre_we && !pre_sel) env_rf[pre_addr] <= pre_data;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic preload(input logic sel, input logic [MW-1:0] addr, input logic [VW-1:0] data);
    if (sel) model_mem[addr] = data;
    else     model_rf[addr] = data;
    pre_sel = sel; pre_addr = addr; pre_data = data; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [OW-1:0] op,
                                input logic [1:0] c1, input logic [MW-1:0] a1,
                                input logic [1:0] c2, input logic [MW-1:0] a2,
                                input logic [1:0] cd, input logic [MW-1:0] ad,
                                input bit hold);
    int start;
    @(negedge clk);
    op_code = op;
    source1_choice = c1; source1_addr = a1;
    source2_choice = c2; source2_addr = a2;
    dest_choice = cd; dest_addr = ad;
    instr_valid = 1'b1;
    start = n_accepts;
    for (int i = 0; i < 30 && n_accepts == start; i++) @(negedge clk);
    if (n_accepts == start) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL accept_timeout: got no accept, required accept within 30 cycles");
    end
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 50 && (exp_q.size() != 0 || instr_ready !== 1'b1); i++) @(negedge clk);
    if (i == 50) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL idle_timeout: got busy, required idle within 50 cycles");
    end
  endtask

  // Tracker: on each accept edge, predicts the retirement from the operand rules.
  initial begin : tracker
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst && instr_valid && instr_ready === 1'b1) begin
        e.op    = op_code;
        e.a     = fetch(source1_choice, source1_addr);
        e.b     = fetch(source2_choice, source2_addr);
        e.res   = alu_fn(op_code, e.a, e.b);
        e.dch   = dest_choice;
        e.daddr = dest_addr;
        e.nrd   = 0;
        e.rd[0] = '0; e.rd[1] = '0;
        if (source1_choice == 2'b01) begin e.rd[e.nrd] = source1_addr; e.nrd++; end
        if (source2_choice == 2'b01) begin e.rd[e.nrd] = source2_addr; e.nrd++; end
        e.lat   = 4 + e.nrd;
        e.acc   = cyc;
        exp_q.push_back(e);
        acc_prev = acc_cur;
        acc_cur = cyc;
        n_accepts++;
      end
      cyc++;
    end
  end

  // Monitor: checks port exclusivity every cycle and the retirement against the queue head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        obs_n = 0;
      end else begin
        check_output("re_we_exclusive", 32'(mem_re & mem_we), 32'd0);
        if (mem_re) begin
          if (obs_n < 2) obs_addr[obs_n] = mem_addr;
          obs_n++;
        end
        if (exp_q.size() == 0) begin
          check_output("idle_strobes", 32'({rf_we, mem_we, done, err}), 32'd0);
        end else if (done) begin
          e = exp_q.pop_front();
          check_output("latency", 32'(cyc - e.acc), 32'(e.lat));
          check_output("alu_op", 32'(alu_op), 32'(e.op));
          check_output("alu_a", 32'(alu_a), 32'(e.a));
          check_output("alu_b", 32'(alu_b), 32'(e.b));
          check_output("err", 32'(err), 32'(e.dch == 2'b10));
          check_output("rf_we", 32'(rf_we), 32'(e.dch == 2'b00));
          check_output("mem_we", 32'(mem_we), 32'(e.dch == 2'b01));
          if (e.dch == 2'b00) begin
            check_output("rf_waddr", 32'(rf_waddr), 32'(e.daddr));
            check_output("rf_wdata", 32'(rf_wdata), 32'(e.res));
            model_rf[e.daddr] = e.res;
          end else if (e.dch == 2'b01) begin
            check_output("mem_waddr", 32'(mem_addr), 32'(e.daddr));
            check_output("mem_wdata", 32'(mem_wdata), 32'(e.res));
            model_mem[e.daddr] = e.res;
          end
          check_output("mem_reads", 32'(obs_n), 32'(e.nrd));
          for (int i = 0; i < e.nrd && i < obs_n && i < 2; i++)
            check_output("mem_raddr", 32'(obs_addr[i]), 32'(e.rd[i]));
          obs_n = 0;
        end else begin
          check_output("early_strobe", 32'({rf_we, mem_we, err}), 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    n_fail++;
    $display("[TB] FAIL watchdog: got no finish, required finish before 500000");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int start;
    #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) preload(1'b0, MW'(i), VW'($urandom));
    for (int i = 0; i < 32; i++) preload(1'b1, MW'(i), VW'($urandom));
    preload(1'b0, 5'd3, 8'h12);
    preload(1'b0, 5'd4, 8'h05);

    // Reset held with a valid register/register add waiting at the input.
    op_code = 4'd0;
    source1_choice = 2'b00; source1_addr = 5'd3;
    source2_choice = 2'b00; source2_addr = 5'd4;
    dest_choice = 2'b00; dest_addr = 5'd7;
    instr_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_output("rst_ready", 32'(instr_ready), 32'd1);
      check_output("rst_strobes", 32'({mem_re, mem_we, rf_we, done, err}), 32'd0);
      check_output("rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
    end
    rst = 1'b1;
    start = n_accepts;
    @(negedge clk);
    check_output("accept_after_reset", 32'(n_accepts - start), 32'd1);
    instr_valid = 1'b0;
    wait_idle();
    check_output("rf7_sum", 32'(env_rf[7]), 32'h17);

    // Memory/memory sources to memory destination.
    preload(1'b1, 5'd2, 8'h40);
    preload(1'b1, 5'd9, 8'h01);
    apply_stimulus(4'd0, 2'b01, 5'd2, 2'b01, 5'd9, 2'b01, 5'd10, 1'b0);
    wait_idle();
    check_output("mem10_sum", 32'(env_mem[10]), 32'h41);

    // Immediate source, none source, immediate destination.
    apply_stimulus(4'd3, 2'b10, 5'h1F, 2'b11, 5'h0A, 2'b10, 5'd3, 1'b0);
    wait_idle();

    // Reset asserted during S2_WT of a memory-destination instruction.
    preload(1'b1, 5'd5, 8'h33);
    preload(1'b1, 5'd6, 8'h44);
    preload(1'b1, 5'd12, 8'hAA);
    apply_stimulus(4'd1, 2'b01, 5'd5, 2'b01, 5'd6, 2'b01, 5'd12, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_output("midrst_ready", 32'(instr_ready), 32'd1);
    check_output("midrst_strobes", 32'({mem_re, mem_we, rf_we, done}), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_output("midrst_no_write", 32'(mem_we), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check_output("mem12_untouched", 32'(env_mem[12]), 32'hAA);
    apply_stimulus(4'd0, 2'b00, 5'd3, 2'b10, 5'd2, 2'b01, 5'd12, 1'b0);
    wait_idle();
    check_output("mem12_after", 32'(env_mem[12]), 32'h14);

    // Back-to-back register instructions with instr_valid held; second reads the first's result.
    apply_stimulus(4'd0, 2'b00, 5'd1, 2'b00, 5'd2, 2'b00, 5'd20, 1'b1);
    apply_stimulus(4'd2, 2'b00, 5'd20, 2'b10, 5'h0F, 2'b00, 5'd21, 1'b0);
    check_output("b2b_accept_gap", 32'(acc_cur - acc_prev), 32'd5);
    wait_idle();

    // Randomized mix of operand locations, opcodes and occasional held valid.
    for (int k = 0; k < 40; k++) begin
      apply_stimulus(OW'($urandom_range(0, 6)),
                     2'($urandom), MW'($urandom),
                     2'($urandom), MW'($urandom),
                     2'($urandom), MW'($urandom),
                     (k < 39) ? bit'($urandom_range(0, 1)) : 1'b0);
    end
    instr_valid = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Multi-cycle sequencer between instruction decode and the processor datapath. It accepts one decoded instruction (op_code, two sources, one destination), fetches operands from the register file, the single-port data memory or the immediate field, and presents them to the combinational ALU. It then writes `alu_out` back to the destination. It owns the single data-memory port, so source and destination memory accesses are serialized.

## Interface

Parameters:
- OPCODE_WIDTH, 4: op_code width
- VALUE_WIDTH, 8: data and ALU operand width
- MEM_WIDTH, 5: address width, shared by register file and data memory

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-low reset
- instr_valid  in  1  decoded instruction present
- instr_ready  out  1  sequencer can accept; high only in IDLE
- op_code  in  OPCODE_WIDTH  operation
- source1_addr, source2_addr, dest_addr  in  MEM_WIDTH each  operand addresses or immediates
- source1_choice, source2_choice, dest_choice  in  2 each  operand location: 00 register, 01 memory, 10 immediate, 11 none
- rf_raddr1, rf_raddr2  out  MEM_WIDTH  register read addresses; read data is combinational
- rf_rdata1, rf_rdata2  in  VALUE_WIDTH  register read data
- rf_we  out  1  register write strobe
- rf_waddr  out  MEM_WIDTH  register write address
- rf_wdata  out  VALUE_WIDTH  register write data
- mem_addr  out  MEM_WIDTH  data-memory address
- mem_re  out  1  memory read request; data valid on mem_rdata the following cycle
- mem_rdata  in  VALUE_WIDTH  memory read data
- mem_we  out  1  memory write strobe
- mem_wdata  out  VALUE_WIDTH  memory write data
- alu_op  out  OPCODE_WIDTH  op_code to ALU
- alu_a, alu_b  out  VALUE_WIDTH  registered operands
- alu_out  in  VALUE_WIDTH  combinational ALU result
- done  out  1  one-cycle pulse when the instruction retires
- err  out  1  one-cycle pulse at retire if dest_choice was 10 (immediate)

## Operation

- States: IDLE, S1_RD, S1_WT, S2_RD, S2_WT, EXEC, WB.
- IDLE: when instr_valid && instr_ready, latch op_code, all addresses and all choices, then go to S1_RD. Inputs are ignored outside IDLE.
- S1_RD, by source1_choice:
  - register: drive rf_raddr1, latch rf_rdata1 into alu_a, go to S2_RD.
  - immediate: alu_a = zero-extended source1_addr, go to S2_RD.
  - none: alu_a = 0, go to S2_RD.
  - memory: mem_addr = source1_addr, mem_re = 1, go to S1_WT.
- S1_WT: latch mem_rdata into alu_a, go to S2_RD.
- S2_RD / S2_WT: same as S1_RD / S1_WT for source 2, using rf_raddr2, rf_rdata2 and alu_b. Next state is EXEC.
- EXEC: alu_op holds the latched op_code. Latch alu_out into the result register, go to WB.
- WB, by dest_choice:
  - register: rf_we = 1, rf_waddr = dest_addr, rf_wdata = result.
  - memory: mem_we = 1, mem_addr = dest_addr, mem_wdata = result.
  - immediate: no write; err = 1.
  - none: no write.
  - In all cases done = 1, then go to IDLE.
- mem_re and mem_we are never high in the same cycle. All strobes are low outside their designated state.
- Same-address hazards are handled by ordering alone: a read in a later instruction sees a write from an earlier instruction, because WB precedes the next IDLE acceptance.

## Timing

- Reset (rst low, asynchronous) forces state IDLE and all outputs to 0 except instr_ready, which is 1. Latched operands and result also clear to 0. A write pending mid-instruction is abandoned and no strobe is issued. Operation resumes on the first clock edge after rst returns high.
- Accept edge is t0. Cycle numbers below count from that edge.
- Latency: with no memory sources, S1_RD is cycle 1, S2_RD cycle 2, EXEC cycle 3, WB cycle 4 (done high). instr_ready is high again in cycle 5.
- Each memory source adds exactly one cycle, so the maximum is done in cycle 6.
- Throughput: one instruction per (latency + 1) cycles. Back-to-back acceptance occurs on the edge ending the first IDLE cycle.
- Outputs are registered or state-decoded. No combinational path runs from instr_valid to any memory or register-file strobe.

## Test plan

- Reset: hold rst low for 2 cycles with instr_valid=1. Required: all strobes 0, instr_ready=1, done=0. Release; the instruction is accepted on the next edge.
- Register/register to register, VALUE_WIDTH=8: rf[3]=0x12, rf[4]=0x05, add opcode, dest reg 7. Required: rf_we=1 in cycle 4 with rf_waddr=7, rf_wdata=0x17, done=1 in cycle 4.
- Memory/memory to memory: mem[2]=0x40, mem[9]=0x01, dest mem 10. Required: mem_re in cycles 1 and 3 at addresses 2 and 9; mem_we=1 in cycle 6 with mem_addr=10, mem_wdata=ALU(0x40,0x01); done in cycle 6.
- Immediate operand plus immediate destination: source1 imm 0x1F, source2 none. Required: alu_a=0x1F, alu_b=0; no write strobes; err=1 and done=1 in cycle 4.
- Mid-operation reset: assert rst low during S2_WT of a memory-destination instruction. Required: immediate return to IDLE with no mem_we ever issued. The next instruction then completes normally.
- Back-to-back: two register instructions with instr_valid held high. Required: second accept at cycle 5, second done at cycle 9. Verify mem_re and mem_we are never high together.
